// File: rtl/product_accumulator_if.sv
// product_accumulator_if
//   Product-in / sum-out handshake bundle for the product accumulator.
//   master : upstream multiplier + downstream consumer side (drives in_valid,
//            product, out_ready; observes in_ready, out_valid, sum, overflow).
//   slave  : the accumulator itself.
interface product_accumulator_if #(
    parameter int ACC_WIDTH = 24
);
    logic                 in_valid;
    logic                 in_ready;
    logic [15:0]          product;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] sum;
    logic                 overflow;

    modport master (
        output in_valid, product, out_ready,
        input  in_ready, out_valid, sum, overflow
    );

    modport slave (
        input  in_valid, product, out_ready,
        output in_ready, out_valid, sum, overflow
    );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator
//   Sums COUNT unsigned 16-bit products into an ACC_WIDTH-bit register and
//   presents the total over a valid/ready handshake (accumulate half of a MAC).
//   clk   : rising-edge clock
//   rst   : synchronous, active-high reset
//   clear : synchronous abort of any partial accumulation / pending result
//   bus   : product_accumulator_if.slave
//           in_valid/in_ready/product  - product input handshake
//           out_valid/out_ready        - result output handshake
//           sum/overflow               - result, held stable while out_valid
module product_accumulator #(
    parameter int ACC_WIDTH = 24,
    parameter int COUNT     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    product_accumulator_if.slave   bus
);
    localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;

    typedef enum logic {ACCUM, DONE} state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0] sum_q, sum_d;
    logic                 overflow_q, overflow_d;

    // One extra bit so the carry out of the accumulator is visible.
    logic [ACC_WIDTH:0]   add_full;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        sum_d      = sum_q;
        overflow_d = overflow_q;
        add_full   = {1'b0, acc_q} + (ACC_WIDTH+1)'(bus.product);

        if (clear) begin
            // Abort: the product on the bus this cycle is dropped as well.
            state_d = ACCUM;
            cnt_d   = '0;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (bus.in_valid) begin
                        if (cnt_q == '0) begin
                            // First product of a set replaces, not adds.
                            acc_d = ACC_WIDTH'(bus.product);
                            ovf_d = 1'b0;
                        end else begin
                            acc_d = add_full[ACC_WIDTH-1:0];
                            ovf_d = ovf_q | add_full[ACC_WIDTH];
                        end
                        if (cnt_q == CNT_W'(COUNT - 1)) begin
                            sum_d      = acc_d;
                            overflow_d = ovf_d;
                            cnt_d      = '0;
                            state_d    = DONE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) state_d = ACCUM;
                end
                default: state_d = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ACCUM;
            cnt_q      <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            sum_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            sum_q      <= sum_d;
            overflow_q <= overflow_d;
        end
    end

    // Handshake outputs come from state alone, so there is no
    // combinational path from in_valid or out_ready.
    assign bus.in_ready  = (state_q == ACCUM);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator
//   Three accumulator instances: A (24-bit, COUNT=8), B (16-bit, COUNT=2),
//   C (24-bit, COUNT=1). Inputs are driven 1 time unit after the rising edge,
//   outputs are sampled at that same point.
module tb_product_accumulator;
    logic        clk = 1'b0;
    logic [2:0]  rst, clr, iv, ordy;
    logic [15:0] prod [3];
    logic [2:0]  ir, ov, of;
    logic [31:0] sm [3];

    int total = 0;
    int bad   = 0;

    int wid [3] = '{24, 16, 24};
    int cnt [3] = '{8, 2, 1};

    product_accumulator_if #(.ACC_WIDTH(24)) ifa ();
    product_accumulator_if #(.ACC_WIDTH(16)) ifb ();
    product_accumulator_if #(.ACC_WIDTH(24)) ifc ();

    product_accumulator #(.ACC_WIDTH(24), .COUNT(8)) dut_a (
        .clk(clk), .rst(rst[0]), .clear(clr[0]), .bus(ifa));
    product_accumulator #(.ACC_WIDTH(16), .COUNT(2)) dut_b (
        .clk(clk), .rst(rst[1]), .clear(clr[1]), .bus(ifb));
    product_accumulator #(.ACC_WIDTH(24), .COUNT(1)) dut_c (
        .clk(clk), .rst(rst[2]), .clear(clr[2]), .bus(ifc));

    assign ifa.in_valid = iv[0];  assign ifa.product = prod[0];  assign ifa.out_ready = ordy[0];
    assign ifb.in_valid = iv[1];  assign ifb.product = prod[1];  assign ifb.out_ready = ordy[1];
    assign ifc.in_valid = iv[2];  assign ifc.product = prod[2];  assign ifc.out_ready = ordy[2];
    assign ir[0] = ifa.in_ready;  assign ov[0] = ifa.out_valid; assign of[0] = ifa.overflow; assign sm[0] = 32'(ifa.sum);
    assign ir[1] = ifb.in_ready;  assign ov[1] = ifb.out_valid; assign of[1] = ifb.overflow; assign sm[1] = 32'(ifb.sum);
    assign ir[2] = ifc.in_ready;  assign ov[2] = ifc.out_valid; assign of[2] = ifc.overflow; assign sm[2] = 32'(ifc.sum);

    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Present one product and hold it until it is accepted (bounded).
    task automatic feed(input int d, input logic [15:0] p);
        int n = 0;
        iv[d]   = 1'b1;
        prod[d] = p;
        while (!ir[d] && n < 100) begin
            tick();
            n++;
        end
        chk("feed ready", 32'(ir[d]), 32'd1);
        tick();
        iv[d] = 1'b0;
    endtask

    // Wait for a result, stall it for 'hold' cycles, then consume it.
    // With offer=1 a stray product is presented during every DONE cycle.
    task automatic collect(input int d, input int hold, input logic [31:0] es,
                           input logic eo, input string nm, input bit offer = 1'b0);
        int n = 0;
        while (!ov[d] && n < 100) begin
            tick();
            n++;
        end
        chk({nm, " valid"}, 32'(ov[d]), 32'd1);
        for (int i = 0; i <= hold; i++) begin
            ordy[d] = (i == hold);
            if (offer) begin
                iv[d]   = 1'b1;
                prod[d] = 16'd500;
            end
            chk({nm, " sum"}, sm[d], es);
            chk({nm, " ovf"}, 32'(of[d]), 32'(eo));
            chk({nm, " in_ready"}, 32'(ir[d]), 32'd0);
            chk({nm, " out_valid held"}, 32'(ov[d]), 32'd1);
            tick();
        end
        ordy[d] = 1'b0;
        iv[d]   = 1'b0;
        chk({nm, " valid drop"}, 32'(ov[d]), 32'd0);
        chk({nm, " ready back"}, 32'(ir[d]), 32'd1);
    endtask

    typedef struct {
        logic [15:0] base;
        logic [15:0] step;
        int          gap;
        logic [31:0] es;
        logic        eo;
    } vec_t;

    vec_t tbl [5];

    initial begin
        longint t, m;
        logic [15:0] p;

        tbl[0] = '{16'd2730,  16'd0,    0, 32'd21840,  1'b0};
        tbl[1] = '{16'd1,     16'd1,    1, 32'd36,     1'b0};
        tbl[2] = '{16'd65535, 16'd0,    2, 32'd524280, 1'b0};
        tbl[3] = '{16'd0,     16'd0,    0, 32'd0,      1'b0};
        tbl[4] = '{16'd1000,  16'd3000, 3, 32'd92000,  1'b0};

        rst = 3'b111; clr = '0; iv = '0; ordy = '0;
        for (int d = 0; d < 3; d++) prod[d] = '0;
        tick(); tick();
        rst = '0;
        for (int d = 0; d < 3; d++) begin
            chk("reset in_ready", 32'(ir[d]), 32'd1);
            chk("reset out_valid", 32'(ov[d]), 32'd0);
            chk("reset sum", sm[d], 32'd0);
            chk("reset ovf", 32'(of[d]), 32'd0);
        end

        // Table vectors on A: product k = base + k*step, 'gap' idle cycles between.
        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < 8; k++) begin
                p = tbl[v].base + 16'(k) * tbl[v].step;
                feed(0, p);
                if (k == 7) begin
                    chk("tbl latency", 32'(ov[0]), 32'd1);
                end else begin
                    repeat (tbl[v].gap) tick();
                end
            end
            collect(0, 0, tbl[v].es, tbl[v].eo, "tbl");
        end

        // Gaps + backpressure: 6 DONE cycles with stray products offered.
        for (int k = 1; k <= 8; k++) begin
            feed(0, 16'(k));
            if (k < 8) tick();
        end
        collect(0, 5, 32'd36, 1'b0, "bp", 1'b1);
        for (int k = 0; k < 8; k++) feed(0, 16'd1);
        collect(0, 0, 32'd8, 1'b0, "after bp");

        // Clear mid-accumulation, with a product presented in the clear cycle.
        for (int k = 0; k < 3; k++) feed(0, 16'd100);
        clr[0] = 1'b1; iv[0] = 1'b1; prod[0] = 16'd999;
        tick();
        clr[0] = 1'b0; iv[0] = 1'b0;
        chk("clear no result", 32'(ov[0]), 32'd0);
        chk("clear ready", 32'(ir[0]), 32'd1);
        for (int k = 0; k < 8; k++) feed(0, 16'd10);
        collect(0, 0, 32'd80, 1'b0, "clear");

        // Reset while a result is pending.
        for (int k = 0; k < 8; k++) feed(0, 16'd50);
        chk("pre-rst valid", 32'(ov[0]), 32'd1);
        tick();
        rst[0] = 1'b1;
        tick();
        rst[0] = 1'b0;
        chk("rst valid", 32'(ov[0]), 32'd0);
        chk("rst sum", sm[0], 32'd0);
        chk("rst ovf", 32'(of[0]), 32'd0);
        chk("rst ready", 32'(ir[0]), 32'd1);
        for (int k = 0; k < 8; k++) feed(0, 16'd1);
        collect(0, 0, 32'd8, 1'b0, "post rst");

        // Overflow on the 16-bit, COUNT=2 instance.
        feed(1, 16'd65535); feed(1, 16'd2);
        collect(1, 0, 32'd1, 1'b1, "ovf");
        feed(1, 16'd3); feed(1, 16'd4);
        collect(1, 0, 32'd7, 1'b0, "ovf next");

        // COUNT=1: every accept is a result.
        feed(2, 16'd65025);
        chk("c1 latency a", 32'(ov[2]), 32'd1);
        collect(2, 0, 32'd65025, 1'b0, "c1 a");
        feed(2, 16'd7);
        chk("c1 latency b", 32'(ov[2]), 32'd1);
        collect(2, 0, 32'd7, 1'b0, "c1 b");

        // Random sets against a plain-arithmetic model: the result is the true
        // total modulo 2^W, and overflow means the true total reached 2^W.
        for (int d = 0; d < 3; d++) begin
            m = 64'd1 << wid[d];
            for (int r = 0; r < 12; r++) begin
                t = 0;
                for (int k = 0; k < cnt[d]; k++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    p = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(49152, 65535))
                                                     : 16'($urandom_range(0, 65535));
                    feed(d, p);
                    t += longint'(p);
                end
                collect(d, int'($urandom_range(0, 3)), 32'(t % m), (t >= m),
                        "rand", 1'($urandom_range(0, 1)));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
